// File: rtl/fpu_sgn_unit.sv
// fpu_sgn_unit: 2-stage FP sign-injection and fmin/fmax unit (RV32F).
// Ports: clk/rstn; flush; in_valid/in_ready with op, x1, x2, rd;
//   out_valid/out_ready with y, out_rd, out_nv, out_illegal; busy.
module fpu_sgn_unit #(
  parameter logic [31:0] CANON_NAN = 32'h7fc00000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic [4:0]  rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic [4:0]  out_rd,
  output logic        out_nv,
  output logic        out_illegal,
  output logic        busy
);

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] x1;
    logic [31:0] x2;
    logic [4:0]  rd;
  } s1_t;

  typedef struct packed {
    logic [31:0] y;
    logic [4:0]  rd;
    logic        nv;
    logic        il;
  } s2_t;

  logic s1_valid;
  logic s2_valid;
  s1_t  s1_q;
  s2_t  s2_q;
  s2_t  s2_d;

  logic s2_ready;
  logic s1_adv;
  logic accept;

  assign s2_ready = !s2_valid || out_ready;
  assign s1_adv   = s1_valid && s2_ready;
  // flush kills the pipe, so nothing is taken in that cycle
  assign in_ready = !flush && (!s1_valid || s1_adv);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else begin
      if (flush)       s1_valid <= 1'b0;
      else if (accept) s1_valid <= 1'b1;
      else if (s1_adv) s1_valid <= 1'b0;
      if (accept) begin
        s1_q.op <= op;
        s1_q.x1 <= x1;
        s1_q.x2 <= x2;
        s1_q.rd <= rd;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid <= 1'b0;
      s2_q     <= '0;
    end else begin
      if (flush)          s2_valid <= 1'b0;
      else if (s1_adv)    s2_valid <= 1'b1;
      else if (out_ready) s2_valid <= 1'b0;
      if (s1_adv && !flush) s2_q <= s2_d;
    end
  end

  logic [31:0] a;
  logic [31:0] b;
  logic        nan_a;
  logic        nan_b;
  logic        snan_a;
  logic        snan_b;
  logic        a_lt_b;
  logic [31:0] min_y;
  logic [31:0] max_y;

  assign a      = s1_q.x1;
  assign b      = s1_q.x2;
  assign nan_a  = (&a[30:23]) && (|a[22:0]);
  assign nan_b  = (&b[30:23]) && (|b[22:0]);
  assign snan_a = nan_a && !a[22];
  assign snan_b = nan_b && !b[22];

  // sign-magnitude order; differing signs make -0 < +0
  always_comb begin
    if (a[31] != b[31])
      a_lt_b = a[31];
    else if (!a[31])
      a_lt_b = a[30:0] < b[30:0];
    else
      a_lt_b = a[30:0] > b[30:0];
  end

  always_comb begin
    min_y = a_lt_b ? a : b;
    max_y = a_lt_b ? b : a;
    if (nan_a && nan_b) begin
      min_y = CANON_NAN;
      max_y = CANON_NAN;
    end else if (nan_a) begin
      min_y = b;
      max_y = b;
    end else if (nan_b) begin
      min_y = a;
      max_y = a;
    end
  end

  logic is_j;
  logic is_jn;
  logic is_jx;
  logic is_min;
  logic is_max;

  assign is_j   = s1_q.op == 3'b000;
  assign is_jn  = s1_q.op == 3'b001;
  assign is_jx  = s1_q.op == 3'b010;
  assign is_min = s1_q.op == 3'b011;
  assign is_max = s1_q.op == 3'b100;

  always_comb begin
    s2_d.y  = a;
    s2_d.rd = s1_q.rd;
    s2_d.nv = 1'b0;
    s2_d.il = 1'b0;
    unique case (1'b1)
      is_j:  s2_d.y = {b[31], a[30:0]};
      is_jn: s2_d.y = {~b[31], a[30:0]};
      is_jx: s2_d.y = {a[31] ^ b[31], a[30:0]};
      is_min: begin
        s2_d.y  = min_y;
        s2_d.nv = snan_a || snan_b;
      end
      is_max: begin
        s2_d.y  = max_y;
        s2_d.nv = snan_a || snan_b;
      end
      default: s2_d.il = 1'b1;
    endcase
  end

  assign out_valid   = s2_valid;
  assign y           = s2_q.y;
  assign out_rd      = s2_q.rd;
  assign out_nv      = s2_q.nv;
  assign out_illegal = s2_q.il;
  assign busy        = s1_valid || s2_valid;

endmodule

// File: doc/fpu_sgn_unit.md
FPU_SGN_UNIT -- requirements
Module: fpu_sgn_unit

Interface
REQ-001 SHALL have parameter CANON_NAN, default 32'h7fc00000, the canonical quiet-NaN result for fmin/fmax.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rstn  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port flush  input  1  synchronous pipeline kill.
REQ-005 SHALL have port in_valid  input  1  operation offered.
REQ-006 SHALL have port in_ready  output  1  operation accepted when high with in_valid.
REQ-007 SHALL have port op  input  3  operation code: 000 fsgnj, 001 fsgnjn, 010 fsgnjx, 011 fmin, 100 fmax; 101-111 illegal.
REQ-008 SHALL have ports x1 and x2  input  32 each  IEEE-754 single-precision source operands.
REQ-009 SHALL have port rd  input  5  destination register tag.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  writeback consumes the result.
REQ-012 SHALL have port y  output  32  result.
REQ-013 SHALL have port out_rd  output  5  tag paired with y.
REQ-014 SHALL have port out_nv  output  1  invalid-operation flag paired with y.
REQ-015 SHALL have port out_illegal  output  1  illegal-op flag paired with y.
REQ-016 SHALL have port busy  output  1  high when either stage holds a valid entry.

Function
REQ-017 SHALL be a 2-stage pipeline:
- S1 registers op, x1, x2, rd.
- S2 registers y, out_rd, out_nv, out_illegal.
- Outputs come directly from S2 registers.
REQ-018 SHALL handshake per stage:
- A transfer occurs when valid and ready are both high.
- S2 loads when it is empty or out_ready is high.
- S1 loads when it is empty or S1 advances into S2.
- in_ready = !s1_valid || s1_advance.
REQ-019 SHALL deliver the result 2 cycles after acceptance (out_valid high on the 2nd rising edge after the in_valid&&in_ready edge) when out_ready is held high.
REQ-020 SHALL sustain one operation per cycle with no bubbles while out_ready is high.
REQ-021 SHALL hold y, out_rd, out_nv and out_illegal stable while out_valid is high and out_ready is low.
REQ-022 SHALL stall S1 while S2 is full and out_ready is low; in_ready then goes low, and no entry is lost or duplicated.
REQ-023 SHALL compute the sign-injection results as:
- fsgnj: {x2[31], x1[30:0]}
- fsgnjn: {~x2[31], x1[30:0]}
- fsgnjx: {x1[31]^x2[31], x1[30:0]}
- out_nv = 0 for all three.
REQ-024 SHALL classify operands as:
- NaN: exponent all ones and mantissa nonzero.
- Signaling NaN: a NaN with mantissa[22] = 0.
REQ-025 SHALL compute fmin and fmax as:
- Both operands NaN: y = CANON_NAN.
- Exactly one NaN: y = the other operand.
- Otherwise the smaller (fmin) or larger (fmax) by IEEE order, with -0 < +0.
- out_nv = 1 if either operand is a signaling NaN.
REQ-026 SHALL, for an illegal op, produce y = x1, out_illegal = 1, out_nv = 0.
REQ-027 SHALL, on flush, clear s1_valid and s2_valid at the next edge:
- flush has priority over a simultaneous acceptance or advance.
- in_ready is 0 during the flush cycle.
- out_valid is 0 in the following cycle.
REQ-028 SHALL pass rd through unchanged to out_rd with its own operation.

Reset
REQ-029 SHALL, while rstn is low, asynchronously force:
- s1_valid = 0, s2_valid = 0, out_valid = 0, busy = 0.
- y = 0, out_rd = 0, out_nv = 0, out_illegal = 0.
- in_ready = 1.
REQ-030 SHALL discard any in-flight operation on reset, with no output produced for it after release.
REQ-031 SHALL accept a new operation in the first cycle after rstn rises.

Verification
REQ-032 SHALL cover: fsgnjn, x1=3F800000, x2=00000000, rd=5, out_ready=1 -> y=BF800000, out_rd=5, out_valid 2 cycles later.
REQ-033 SHALL cover: fsgnjx, x1=BF800000, x2=80000000 -> y=3F800000, out_nv=0.
REQ-034 SHALL cover: fmin, x1=00000000, x2=80000000 -> y=80000000; fmax with the same operands -> y=00000000.
REQ-035 SHALL cover: fmax, x1=7F800001 (sNaN), x2=40000000 -> y=40000000, out_nv=1; fmin, x1=x2=7FC00001 -> y=7FC00000, out_nv=0.
REQ-036 SHALL cover: 4 back-to-back ops with out_ready low for 3 cycles -> in_ready drops after 2 accepted, all 4 results emerge in order with correct tags, none lost.
REQ-037 SHALL cover: flush asserted with both stages full and in_valid high -> next cycle out_valid=0, busy=0, and the flush-cycle op is not accepted; rstn pulsed low mid-stream -> outputs zero immediately, in_ready=1.
